// File: rtl/i2s_tx_master.sv
// I2S / left-justified stereo transmitter and clock master. bck and lrck are
// produced by dividing sck; every register runs on posedge sck.
module i2s_tx_master #(
    parameter int MCLK_DIV     = 8,
    parameter int SLOT_BITS    = 32,
    parameter int SAMPLE_WIDTH = 24,
    parameter int FORMAT       = 0
) (
    input  logic                    sck,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] left_data,
    input  logic [SAMPLE_WIDTH-1:0] right_data,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    bck,
    output logic                    lrck,
    output logic                    sdata,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
    localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int LEAD       = (FORMAT == 0) ? 1 : 0;

    logic [DIV_W-1:0]        div_cnt_reg, div_cnt_next;
    logic [BIT_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic                    started_reg, started_next;
    logic                    full_reg, full_next;
    logic [SAMPLE_WIDTH-1:0] buf_l_reg, buf_l_next;
    logic [SAMPLE_WIDTH-1:0] buf_r_reg, buf_r_next;
    logic [SAMPLE_WIDTH-1:0] act_l_reg, act_l_next;
    logic [SAMPLE_WIDTH-1:0] act_r_reg, act_r_next;
    logic                    bck_reg, lrck_reg, sdata_reg, ready_reg;

    logic                    fall_strobe, rise_strobe, last_bit, load, accept;
    logic                    slot;
    logic [BIT_W-1:0]        pos;
    logic [SAMPLE_WIDTH-1:0] sel;
    logic                    data_bit;

    assign fall_strobe = enable && (div_cnt_reg == DIV_W'(MCLK_DIV - 1));
    assign rise_strobe = enable && (div_cnt_reg == DIV_W'(MCLK_DIV / 2 - 1));
    assign last_bit    = (bit_cnt_reg == BIT_W'(FRAME_BITS - 1));
    // A frame is loaded at the wrap to bit 0, or at the very first strobe after enabling.
    assign load        = rst_n && fall_strobe && (!started_reg || last_bit);
    assign accept      = sample_valid && ready_reg;

    always_comb begin
        div_cnt_next = '0;
        bit_cnt_next = '0;
        started_next = 1'b0;
        act_l_next   = '0;
        act_r_next   = '0;
        full_next    = full_reg;
        buf_l_next   = buf_l_reg;
        buf_r_next   = buf_r_reg;

        if (enable) begin
            div_cnt_next = fall_strobe ? '0 : div_cnt_reg + DIV_W'(1);
            started_next = started_reg || fall_strobe;
            bit_cnt_next = bit_cnt_reg;
            act_l_next   = act_l_reg;
            act_r_next   = act_r_reg;
            if (fall_strobe) begin
                bit_cnt_next = (!started_reg || last_bit) ? '0 : bit_cnt_reg + BIT_W'(1);
            end
            if (load) begin
                act_l_next = full_reg ? buf_l_reg : '0;
                act_r_next = full_reg ? buf_r_reg : '0;
            end
        end

        // An accept coinciding with a load from an empty buffer refills it for the next frame.
        if (load) begin
            full_next = 1'b0;
        end
        if (accept) begin
            full_next  = 1'b1;
            buf_l_next = left_data;
            buf_r_next = right_data;
        end

        slot = (bit_cnt_next >= BIT_W'(SLOT_BITS));
        pos  = slot ? bit_cnt_next - BIT_W'(SLOT_BITS) : bit_cnt_next;
        sel  = slot ? act_r_next : act_l_next;

        data_bit = 1'b0;
        for (int i = 0; i < SAMPLE_WIDTH; i++) begin
            if (int'(pos) == SAMPLE_WIDTH - 1 - i + LEAD) begin
                data_bit = sel[i];
            end
        end
    end

    always_ff @(posedge sck) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            started_reg <= 1'b0;
            full_reg    <= 1'b0;
            buf_l_reg   <= '0;
            buf_r_reg   <= '0;
            act_l_reg   <= '0;
            act_r_reg   <= '0;
            bck_reg     <= 1'b0;
            lrck_reg    <= 1'b0;
            sdata_reg   <= 1'b0;
            ready_reg   <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            started_reg <= started_next;
            full_reg    <= full_next;
            buf_l_reg   <= buf_l_next;
            buf_r_reg   <= buf_r_next;
            act_l_reg   <= act_l_next;
            act_r_reg   <= act_r_next;
            ready_reg   <= ~full_next;

            if (!enable) begin
                bck_reg   <= 1'b0;
                lrck_reg  <= 1'b0;
                sdata_reg <= 1'b0;
            end else if (fall_strobe) begin
                bck_reg   <= 1'b0;
                lrck_reg  <= (FORMAT == 1) ? ~slot : slot;
                sdata_reg <= data_bit;
            end else if (rise_strobe) begin
                bck_reg   <= 1'b1;
            end
        end
    end

    assign sample_ready = ready_reg;
    assign bck          = bck_reg;
    assign lrck         = lrck_reg;
    assign sdata        = sdata_reg;
    assign frame_start  = load;
    assign underrun     = load && !full_reg;

endmodule

// File: doc/i2s_tx_master.md
Name: i2s_tx_master

Overview:
Parametrised I2S / left-justified audio transmitter and clock master. It divides the master clock sck to produce bck and lrck, and serialises stereo samples onto sdata. It accepts one stereo sample per frame through a valid/ready handshake backed by a one-entry holding buffer. It replaces the fixed divide-by-8/64 oscillator in the sound path. All logic runs in the sck domain, and no logic is clocked on derived clocks.

Parameters:
MCLK_DIV, 8, sck cycles per bck period; even, >=2
SLOT_BITS, 32, bck periods per channel slot (frame = 2*SLOT_BITS bck)
SAMPLE_WIDTH, 24, bits per channel sample; <=SLOT_BITS, and <=SLOT_BITS-1 when FORMAT=0
FORMAT, 0, 0 = Philips I2S (MSB one bck after lrck edge, left when lrck=0); 1 = left-justified (MSB aligned to lrck edge, left when lrck=1)

Ports:
sck  in  1  master clock, all logic on posedge
rst_n  in  1  synchronous reset, active-low
enable  in  1  run; 0 = hold serial interface idle
left_data  in  SAMPLE_WIDTH  left sample, two's complement
right_data  in  SAMPLE_WIDTH  right sample
sample_valid  in  1  left/right pair presented
sample_ready  out  1  holding buffer empty; transfer on valid&&ready
bck  out  1  bit clock, registered
lrck  out  1  word select, registered
sdata  out  1  serial data, registered
frame_start  out  1  1-sck pulse when a new frame is loaded
underrun  out  1  1-sck pulse when a frame is loaded with the buffer empty

Behaviour:
- Reset (rst_n=0 at posedge sck): div_cnt=0, bit_cnt=0, holding buffer empty, shift registers=0, bck=0, lrck=0, sdata=0, frame_start=0, underrun=0, sample_ready=0. sample_ready=1 on the first cycle after release. Reset mid-frame aborts the frame and discards buffered data.
- div_cnt counts 0..MCLK_DIV-1 and wraps while enable=1.
  - bck goes 1 on the edge where div_cnt goes MCLK_DIV/2-1 -> MCLK_DIV/2.
  - bck goes 0 on the edge where div_cnt wraps to 0 (the "fall strobe").
  - Duty cycle is exactly 50%.
- bit_cnt counts 0..2*SLOT_BITS-1 and advances on each fall strobe, wrapping to 0.
  - Slot: s = bit_cnt >= SLOT_BITS (0 = left, 1 = right).
  - Position: p = bit_cnt mod SLOT_BITS.
- On each fall strobe, lrck and sdata update to the values for the new bit_cnt.
  - lrck = s for FORMAT=0; lrck = ~s for FORMAT=1.
  - FORMAT=1: sdata = sample[SAMPLE_WIDTH-1-p] for p<SAMPLE_WIDTH, else 0.
  - FORMAT=0: sdata = sample[SAMPLE_WIDTH-p] for 1<=p<=SAMPLE_WIDTH, else 0; p=0 always drives 0.
  - Receivers sample sdata on the bck rising edge.
- Frame load happens on the fall strobe where bit_cnt wraps to 0, and on the first fall strobe after enable rises.
  - If the buffer is full: the left/right active registers take the buffer contents, and the buffer empties.
  - If the buffer is empty: the active registers load 0, and underrun pulses on the same cycle.
  - frame_start pulses on every frame load.
- Handshake:
  - sample_ready is registered and equals ~full.
  - Accept on valid && ready captures left_data/right_data into the buffer; ready = 0 from the next cycle.
  - The buffer is freed at frame load; ready = 1 on the following cycle.
  - There is no bypass: an accept in the same cycle as a load from an empty buffer still yields underrun, and the accepted pair plays in the next frame.
  - valid may be held without ready; the inputs are not sampled until acceptance.
- enable=0:
  - div_cnt and bit_cnt are forced to 0; bck=0, lrck=0, sdata=0; no pulses.
  - The buffer and handshake keep operating.
  - Dropping enable mid-frame aborts the frame, and active data is lost.
  - On re-enable, the first fall strobe occurs MCLK_DIV cycles after enable is sampled high.

Test Plan:
- Defaults, enable=1, no samples -> bck period 8 sck with 4 high/4 low; lrck toggles every 256 sck; sdata stays 0; underrun+frame_start pulse every 512 sck.
- FORMAT=0, push L=24'hA5F00F, R=24'h123456 before the first load -> in the lrck=0 slot, bits p1..p24 = A5F00F MSB-first and p0 and p25..31 = 0; the right slot carries 123456 the same way; no underrun that frame.
- FORMAT=1, same data -> left slot has lrck=1 and the MSB at p0; right slot has lrck=0; lrck and sdata change only on bck falling edges.
- Hold valid high continuously -> exactly one accept per 512 sck, each ready rise 1 cycle after frame_start; no underrun after the first frame; no sample lost or duplicated.
- Accept in the same cycle as a load from an empty buffer -> underrun=1 that cycle; the pair is transmitted in the following frame.
- rst_n=0 or enable=0 mid-slot, then resume -> outputs go to 0 on the next edge; after re-enable the frame restarts at bit_cnt=0 with the first fall strobe 8 sck later.
